pxl_wb_initiator: RTL

PXL_WB_INITIATOR -- requirements
Module: pxl_wb_initiator

---
 rtl/pxl_wbm_pkg.sv | 19 +
 rtl/pxl_wbm_timer.sv | 26 ++
 rtl/pxl_wb_initiator.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pxl_wbm_pkg.sv
// Shared definitions for the pixel Wishbone initiator: FSM encoding, default
// target base nibble and timeout counter width.
package pxl_wbm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } wbm_state_t;

   localparam logic [3:0]  PXL_WBM_BASE_NIB = 4'h3;
   localparam int unsigned PXL_WBM_CNT_W    = 10;

   // Reads always fetch the whole word, so byte lanes only matter for writes.
   function automatic logic [3:0] wbm_bus_sel(input logic we, input logic [3:0] sel);
      return we ? sel : 4'hF;
   endfunction

endpackage

// File: rtl/pxl_wbm_timer.sv
// Bus-cycle timeout counter; o_expired is high during the i_max-th enabled
// cycle after a clear.
module pxl_wbm_timer
   import pxl_wbm_pkg::*;
(
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   input  logic                     i_enable,
   input  logic                     i_clear,
   input  logic [PXL_WBM_CNT_W-1:0] i_max,
   output logic                     o_expired
);

   logic [PXL_WBM_CNT_W-1:0] r_count;

   assign o_expired = i_enable && (r_count == (i_max - {{(PXL_WBM_CNT_W-1){1'b0}}, 1'b1}));

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || i_clear) begin
         r_count <= '0;
      end else if (i_enable && !o_expired) begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: rtl/pxl_wb_initiator.sv
// Single-command Wishbone classic initiator with address filtering.
// Define PXL_WBM_TIMEOUT_EN to abort bus cycles that see no ack in TIMEOUT_CYCLES.
module pxl_wb_initiator
   import pxl_wbm_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [3:0]  USER_BASE_NIB  = PXL_WBM_BASE_NIB
)(
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_we_i,
   input  logic [3:0]  cmd_sel_i,
   input  logic [31:0] cmd_adr_i,
   input  logic [31:0] cmd_dat_i,
   output logic        rsp_valid_o,
   output logic        rsp_err_o,
   output logic [31:0] rsp_dat_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic        wbm_ack_i,
   input  logic [31:0] wbm_dat_i
);

   wbm_state_t  r_state,      w_state_next;
   logic        r_cmd_ready,  w_cmd_ready_next;
   logic        r_cyc,        w_cyc_next;
   logic        r_stb,        w_stb_next;
   logic        r_we,         w_we_next;
   logic [3:0]  r_sel,        w_sel_next;
   logic [31:0] r_adr,        w_adr_next;
   logic [31:0] r_dat,        w_dat_next;
   logic        r_rsp_valid,  w_rsp_valid_next;
   logic        r_rsp_err,    w_rsp_err_next;
   logic [31:0] r_rsp_dat,    w_rsp_dat_next;
   logic        w_timeout;

`ifdef PXL_WBM_TIMEOUT_EN
   localparam logic [PXL_WBM_CNT_W-1:0] TIMEOUT_MAX = PXL_WBM_CNT_W'(TIMEOUT_CYCLES);

   pxl_wbm_timer u_timer (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_i  (wb_rst_i),
      .i_enable  (r_state == BUS),
      .i_clear   (r_state != BUS),
      .i_max     (TIMEOUT_MAX),
      .o_expired (w_timeout)
   );
`else
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      w_state_next     = r_state;
      w_cyc_next       = r_cyc;
      w_stb_next       = r_stb;
      w_we_next        = r_we;
      w_sel_next       = r_sel;
      w_adr_next       = r_adr;
      w_dat_next       = r_dat;
      w_rsp_valid_next = 1'b0;
      w_rsp_err_next   = r_rsp_err;
      w_rsp_dat_next   = r_rsp_dat;

      case (r_state)
         IDLE: begin
            if (cmd_valid_i) begin
               if (cmd_adr_i[31:28] == USER_BASE_NIB) begin
                  w_state_next = BUS;
                  w_cyc_next   = 1'b1;
                  w_stb_next   = 1'b1;
                  w_we_next    = cmd_we_i;
                  w_sel_next   = wbm_bus_sel(cmd_we_i, cmd_sel_i);
                  w_adr_next   = cmd_adr_i;
                  w_dat_next   = cmd_dat_i;
               end else begin
                  w_state_next     = RESP;
                  w_rsp_valid_next = 1'b1;
                  w_rsp_err_next   = 1'b1;
                  w_rsp_dat_next   = '0;
               end
            end
         end
         BUS: begin
            // A late ack in the same cycle as the timeout still completes normally.
            if (wbm_ack_i) begin
               w_state_next     = RESP;
               w_cyc_next       = 1'b0;
               w_stb_next       = 1'b0;
               w_rsp_valid_next = 1'b1;
               w_rsp_err_next   = 1'b0;
               w_rsp_dat_next   = r_we ? 32'h0 : wbm_dat_i;
            end else if (w_timeout) begin
               w_state_next     = RESP;
               w_cyc_next       = 1'b0;
               w_stb_next       = 1'b0;
               w_rsp_valid_next = 1'b1;
               w_rsp_err_next   = 1'b1;
               w_rsp_dat_next   = '0;
            end
         end
         RESP: begin
            w_state_next   = IDLE;
            w_rsp_err_next = 1'b0;
         end
         default: begin
            w_state_next = IDLE;
            w_cyc_next   = 1'b0;
            w_stb_next   = 1'b0;
         end
      endcase

      w_cmd_ready_next = (w_state_next == IDLE);
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state     <= IDLE;
         r_cmd_ready <= 1'b1;
         r_cyc       <= 1'b0;
         r_stb       <= 1'b0;
         r_we        <= 1'b0;
         r_sel       <= '0;
         r_adr       <= '0;
         r_dat       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_dat   <= '0;
      end else begin
         r_state     <= w_state_next;
         r_cmd_ready <= w_cmd_ready_next;
         r_cyc       <= w_cyc_next;
         r_stb       <= w_stb_next;
         r_we        <= w_we_next;
         r_sel       <= w_sel_next;
         r_adr       <= w_adr_next;
         r_dat       <= w_dat_next;
         r_rsp_valid <= w_rsp_valid_next;
         r_rsp_err   <= w_rsp_err_next;
         r_rsp_dat   <= w_rsp_dat_next;
      end
   end

   assign cmd_ready_o = r_cmd_ready;
   assign wbm_cyc_o   = r_cyc;
   assign wbm_stb_o   = r_stb;
   assign wbm_we_o    = r_we;
   assign wbm_sel_o   = r_sel;
   assign wbm_adr_o   = r_adr;
   assign wbm_dat_o   = r_dat;
   assign rsp_valid_o = r_rsp_valid;
   assign rsp_err_o   = r_rsp_err;
   assign rsp_dat_o   = r_rsp_dat;

endmodule
